// File: rtl/counter_seq_pkg.sv
// Shared types and helpers for counter_sequencer: FSM state encoding,
// speed codes and the speed-code to tick-counter reload value mapping.
package counter_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SPD_FULL    = 2'b00;
   localparam logic [1:0] SPD_1HZ     = 2'b01;
   localparam logic [1:0] SPD_HALF    = 2'b10;
   localparam logic [1:0] SPD_QUARTER = 2'b11;

   // Reload value of the tick down-counter; a tick fires every Limit+1 RUN cycles.
   function automatic logic [31:0] speed_limit(input logic [1:0] speed,
                                               input int unsigned cf);
      case (speed)
         SPD_FULL: return '0;
         SPD_1HZ:  return cf - 1;
         SPD_HALF: return cf * 2 - 1;
         default:  return cf * 4 - 1;
      endcase
   endfunction

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Rate-enable generator: a 32-bit down-counter that ticks on zero and
// reloads Limit; Load forces a reload, Hold freezes it.
module tick_gen (
   input  logic        ClockIn,
   input  logic        Reset,
   input  logic        Load,
   input  logic        Hold,
   input  logic [31:0] Limit,
   output logic        Tick
);

   logic [31:0] count;

   assign Tick = !Hold && (count == '0);

   always_ff @(posedge ClockIn) begin
      if (!Reset) begin
         count <= '0;
      end else if (Load) begin
         count <= Limit;
      end else if (!Hold) begin
         count <= (count == '0) ? Limit : count - 32'd1;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/stop sequencer for the rate-divided display counter.
// Optional down-count mode (Dir input) enabled by defining COUNTER_SEQ_DOWN_EN.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 500,
   parameter int unsigned WIDTH           = 4
) (
   input  logic             ClockIn,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Pause,
   input  logic             Stop,
   input  logic [1:0]       Speed,
   input  logic [WIDTH-1:0] Target,
   input  logic             Repeat,
`ifdef COUNTER_SEQ_DOWN_EN
   input  logic             Dir,
`endif
   output logic [WIDTH-1:0] CounterValue,
   output logic             Tick,
   output logic             Busy,
   output logic             Done,
   output logic             Wrap,
   output logic [1:0]       State
);

   state_t           cur_state;
   logic [1:0]       speed_q;
   logic [WIDTH-1:0] target_q;
   logic             repeat_q;
   logic             gen_tick;
   logic             accept;
   logic [31:0]      limit;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] reload_val;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] step_val;

   assign accept = Start && !Stop && (cur_state == IDLE || cur_state == DONE);
   // On an accepted Start the limit comes straight from the inputs being latched.
   assign limit  = accept ? speed_limit(Speed, CLOCK_FREQUENCY)
                          : speed_limit(speed_q, CLOCK_FREQUENCY);

`ifdef COUNTER_SEQ_DOWN_EN
   logic dir_q;
   assign start_val  = Dir ? Target : '0;
   assign reload_val = dir_q ? target_q : '0;
   assign term_val   = dir_q ? '0 : target_q;
   assign step_val   = dir_q ? CounterValue - WIDTH'(1) : CounterValue + WIDTH'(1);
`else
   assign start_val  = '0;
   assign reload_val = '0;
   assign term_val   = target_q;
   assign step_val   = CounterValue + WIDTH'(1);
`endif

   tick_gen u_tick_gen (
      .ClockIn (ClockIn),
      .Reset   (Reset),
      .Load    (accept),
      .Hold    (cur_state != RUN),
      .Limit   (limit),
      .Tick    (gen_tick)
   );

   assign Tick  = gen_tick && !Stop;
   assign Busy  = (cur_state == RUN) || (cur_state == PAUSE);
   assign Done  = (cur_state == DONE);
   assign State = cur_state;

   always_ff @(posedge ClockIn) begin
      if (!Reset) begin
         cur_state    <= IDLE;
         CounterValue <= '0;
         Wrap         <= 1'b0;
         speed_q      <= SPD_FULL;
         target_q     <= '0;
         repeat_q     <= 1'b0;
`ifdef COUNTER_SEQ_DOWN_EN
         dir_q        <= 1'b0;
`endif
      end else begin
         Wrap <= 1'b0;
         case (cur_state)
            IDLE, DONE: begin
               if (Stop && cur_state == DONE) begin
                  cur_state    <= IDLE;
                  CounterValue <= '0;
               end else if (accept) begin
                  cur_state    <= RUN;
                  speed_q      <= Speed;
                  target_q     <= Target;
                  repeat_q     <= Repeat;
                  CounterValue <= start_val;
`ifdef COUNTER_SEQ_DOWN_EN
                  dir_q        <= Dir;
`endif
               end
            end
            RUN: begin
               if (Stop) begin
                  cur_state    <= IDLE;
                  CounterValue <= '0;
               end else begin
                  if (Pause) cur_state <= PAUSE;
                  if (gen_tick) begin
                     if (CounterValue != term_val) begin
                        CounterValue <= step_val;
                     end else if (repeat_q) begin
                        CounterValue <= reload_val;
                        Wrap         <= 1'b1;
                     end else begin
                        // Reaching the terminal count takes precedence over a same-cycle Pause.
                        cur_state <= DONE;
                     end
                  end
               end
            end
            PAUSE: begin
               if (Stop) begin
                  cur_state    <= IDLE;
                  CounterValue <= '0;
               end else if (Pause) begin
                  cur_state <= RUN;
               end
            end
            default: cur_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized self-checking bench for counter_sequencer against a cycle-count
// reference model; define COUNTER_SEQ_DOWN_EN to exercise the Dir port.
module tb_counter_sequencer;

   localparam int CF = 4;
   localparam int W  = 4;

   logic         ClockIn = 1'b0;
   logic         Reset, Start, Pause, Stop, Repeat;
   logic [1:0]   Speed;
   logic [W-1:0] Target;
`ifdef COUNTER_SEQ_DOWN_EN
   logic         Dir = 1'b0;
`endif
   logic [W-1:0] CounterValue;
   logic         Tick, Busy, Done, Wrap;
   logic [1:0]   State;

   int total = 0;
   int bad   = 0;

   counter_sequencer #(.CLOCK_FREQUENCY(CF), .WIDTH(W)) dut (
      .ClockIn      (ClockIn),
      .Reset        (Reset),
      .Start        (Start),
      .Pause        (Pause),
      .Stop         (Stop),
      .Speed        (Speed),
      .Target       (Target),
      .Repeat       (Repeat),
`ifdef COUNTER_SEQ_DOWN_EN
      .Dir          (Dir),
`endif
      .CounterValue (CounterValue),
      .Tick         (Tick),
      .Busy         (Busy),
      .Done         (Done),
      .Wrap         (Wrap),
      .State        (State)
   );

   always #5 ClockIn = ~ClockIn;

   // Reference model: states as plain numbers, rate tracked as RUN cycles
   // elapsed within the current tick period.
   int m_state, m_cnt, m_elapsed, m_period, m_target, m_wrap;
   bit m_rep, m_dir;

   task automatic check_eq(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_tick();
      return (m_state == 1 && m_elapsed == m_period - 1 && !Stop) ? 1 : 0;
   endfunction

   task automatic model_edge();
      bit fire;
      int term;
      if (!Reset) begin
         m_state = 0; m_cnt = 0; m_wrap = 0;
         return;
      end
      fire   = (m_state == 1 && m_elapsed == m_period - 1);
      m_wrap = 0;
      case (m_state)
         0, 3: begin
            if (Stop && m_state == 3) begin
               m_state = 0; m_cnt = 0;
            end else if (Start && !Stop) begin
               m_period  = (Speed == 0) ? 1 : (CF << (Speed - 1));
               m_target  = Target;
               m_rep     = Repeat;
`ifdef COUNTER_SEQ_DOWN_EN
               m_dir     = Dir;
`else
               m_dir     = 0;
`endif
               m_cnt     = m_dir ? m_target : 0;
               m_elapsed = 0;
               m_state   = 1;
            end
         end
         1: begin
            if (Stop) begin
               m_state = 0; m_cnt = 0;
            end else begin
               if (fire) begin
                  m_elapsed = 0;
                  term = m_dir ? 0 : m_target;
                  if (m_cnt != term) m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
                  else if (m_rep) begin
                     m_cnt  = m_dir ? m_target : 0;
                     m_wrap = 1;
                  end else m_state = 3;
               end else begin
                  m_elapsed++;
               end
               if (Pause && m_state == 1) m_state = 2;
            end
         end
         default: begin
            if (Stop) begin
               m_state = 0; m_cnt = 0;
            end else if (Pause) m_state = 1;
         end
      endcase
   endtask

   task automatic cycle(input logic st, input logic pa, input logic sp, input logic rs);
      Start = st; Pause = pa; Stop = sp; Reset = rs;
      #1;
      check_eq("tick", Tick, model_tick());
      @(posedge ClockIn);
      model_edge();
      #1;
      check_eq("state", State, m_state);
      check_eq("count", CounterValue, m_cnt);
      check_eq("busy", Busy, (m_state == 1 || m_state == 2) ? 1 : 0);
      check_eq("done", Done, (m_state == 3) ? 1 : 0);
      check_eq("wrap", Wrap, m_wrap);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      Speed = 2'd1; Target = '0; Repeat = 1'b0;
      m_state = 0; m_cnt = 0; m_elapsed = 0; m_period = 1; m_target = 0;
      m_wrap = 0; m_rep = 0; m_dir = 0;

      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset_state", State, 0);
      check_eq("reset_count", CounterValue, 0);

      // Basic run, 1 Hz rate, stop at 3
      Speed = 2'd1; Target = 4'd3; Repeat = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(18);
      check_eq("basic_done", Done, 1);
      check_eq("basic_hold", CounterValue, 3);

      // Full-speed repeat with wrap
      Speed = 2'd0; Target = 4'd2; Repeat = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(10);

      // Pause / resume
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      Speed = 2'd1; Target = 4'd15; Repeat = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      idle_cycles(10);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      idle_cycles(6);

      // Start while running ignored, then Stop+Pause together
      Target = 4'd9; Speed = 2'd0;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(3);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("prio_busy", Busy, 0);

      // Reset mid-run, then Target=0 single tick run
      Speed = 2'd0; Target = 4'd9; Repeat = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(5);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      Target = 4'd0;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(3);
      check_eq("t0_done", Done, 1);

`ifdef COUNTER_SEQ_DOWN_EN
      // Down count 3,2,1,0 then DONE
      Dir = 1'b1; Speed = 2'd0; Target = 4'd3; Repeat = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(6);
      check_eq("down_done", Done, 1);
`endif

      for (int i = 0; i < 4000; i++) begin
         Speed  = 2'($urandom_range(3));
         Target = W'($urandom_range(15));
         Repeat = 1'($urandom_range(1));
`ifdef COUNTER_SEQ_DOWN_EN
         Dir    = 1'($urandom_range(1));
`endif
         cycle(($urandom_range(7) == 0), ($urandom_range(15) == 0),
               ($urandom_range(40) == 0), ($urandom_range(300) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
